// File: rtl/alu_issue_stage_if.sv
// Instruction channel into the ALU issue stage: valid/ready handshake plus
// the decoded instruction fields.
interface alu_issue_stage_if #(
  parameter int WIDTH = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [1:0]       in_rd;
  logic [1:0]       in_rs1;
  logic [1:0]       in_rs2;
  logic             in_imm_en;
  logic [WIDTH-1:0] in_imm;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    output in_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Sequencing stage in front of the combinational ALU: one instruction per
// IDLE->EXEC->WB pass, 4-entry register file, registered result and flags.
module alu_issue_stage #(
  parameter int WIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_stage_if.slave  ins,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [3:0]        alu_sel,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_error,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [3:0]        flags,
  output logic              err_sticky,
  input  logic [1:0]        dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  // Operands are resolved at capture time. Nothing writes the register file
  // between the handshake and EXEC, so this equals an EXEC-time read, and
  // the ALU inputs stay frozen through WB and IDLE.
  typedef struct packed {
    logic [3:0]       op;
    logic [1:0]       rd;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } ins_t;

  state_t                  state, state_nx;
  ins_t                    ins_q;
  logic [3:0][WIDTH-1:0]   rf;
  logic                    rdy;
  logic                    hs;

  assign ins.in_ready = rdy;
  assign hs           = ins.in_valid && rdy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (ins.in_valid) state_nx = EXEC;
      end
      EXEC: state_nx = WB;
      WB: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ins_q      <= '0;
      rf         <= '0;
      result     <= '0;
      flags      <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (hs) begin
        ins_q.op <= ins.in_op;
        ins_q.rd <= ins.in_rd;
        ins_q.a  <= rf[ins.in_rs1];
        ins_q.b  <= ins.in_imm_en ? ins.in_imm : rf[ins.in_rs2];
      end
      if (state == EXEC) begin
        result <= alu_out;
        flags  <= {alu_error, alu_overflow, alu_carry, alu_zero};
      end
      // An errored op suppresses the writeback and only raises the sticky bit.
      if (state == WB) begin
        if (!flags[3]) rf[ins_q.rd] <= result;
        else           err_sticky   <= 1'b1;
      end
    end
  end

  assign alu_a    = ins_q.a;
  assign alu_b    = ins_q.b;
  assign alu_sel  = ins_q.op;
  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small 2-bit ALU stand-in.
module tb_alu_issue_stage;
  localparam int W = 2;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR  = 4'd3, OP_XOR = 4'd4, OP_BAD = 4'd15;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] alu_a, alu_b, alu_out, result, dbg_data;
  logic [3:0]   alu_sel, flags;
  logic         alu_error, alu_zero, alu_carry, alu_overflow;
  logic         done, err_sticky;
  logic [1:0]   dbg_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int hs_n = 0;
  int hs_cyc [4];

  alu_issue_stage_if #(.WIDTH(W)) ins_if ();

  alu_issue_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ins(ins_if),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_error(alu_error), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .done(done), .result(result), .flags(flags), .err_sticky(err_sticky),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU stand-in: undefined opcodes raise error and output 0.
  always_comb begin
    logic [W:0] s;
    s            = '0;
    alu_out      = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_error    = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = s[W-1:0]; alu_carry = s[W];
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
      end
      OP_SUB: begin
        s = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out = s[W-1:0]; alu_carry = s[W];
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
      end
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      default: alu_error = 1'b1;
    endcase
    alu_zero = (alu_out == '0);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (ins_if.in_valid && ins_if.in_ready && hs_n < 4) begin
      hs_cyc[hs_n] <= cyc;
      hs_n         <= hs_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [W-1:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic imm_en, input logic [W-1:0] imm);
    ins_if.in_op     = op;
    ins_if.in_rd     = rd;
    ins_if.in_rs1    = rs1;
    ins_if.in_rs2    = rs2;
    ins_if.in_imm_en = imm_en;
    ins_if.in_imm    = imm;
  endtask

  // Handshake one instruction and return at #1 into its EXEC cycle.
  task automatic start(input string tag, input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2, input logic imm_en,
                       input logic [W-1:0] imm, input logic [W-1:0] ea, input logic [W-1:0] eb);
    int n;
    drive(op, rd, rs1, rs2, imm_en, imm);
    ins_if.in_valid = 1'b1;
    n = 0;
    while (!ins_if.in_ready && n < 10) begin
      tick();
      n++;
    end
    chk({tag, " ready"}, 32'(ins_if.in_ready), 32'd1);
    tick();
    ins_if.in_valid = 1'b0;
    chk({tag, " exec_ready"}, 32'(ins_if.in_ready), 32'd0);
    chk({tag, " alu_a"}, 32'(alu_a), 32'(ea));
    chk({tag, " alu_b"}, 32'(alu_b), 32'(eb));
    chk({tag, " alu_sel"}, 32'(alu_sel), 32'(op));
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [1:0] rd,
                     input logic [1:0] rs1, input logic [1:0] rs2, input logic imm_en,
                     input logic [W-1:0] imm, input logic [W-1:0] ea, input logic [W-1:0] eb,
                     input logic [W-1:0] eres, input logic [3:0] eflags);
    start(tag, op, rd, rs1, rs2, imm_en, imm, ea, eb);
    chk({tag, " exec_done"}, 32'(done), 32'd0);
    tick();
    chk({tag, " wb_done"}, 32'(done), 32'd1);
    chk({tag, " result"}, 32'(result), 32'(eres));
    chk({tag, " flags"}, 32'(flags), 32'(eflags));
    tick();
    chk({tag, " idle_done"}, 32'(done), 32'd0);
    chk({tag, " alu_sel_held"}, 32'(alu_sel), 32'(op));
  endtask

  initial begin
    logic [W-1:0] v;
    int dc;

    rst = 1'b1;
    dbg_addr = '0;
    ins_if.in_valid = 1'b0;
    drive(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, '0);
    tick(); tick();
    rst = 1'b0;
    chk("rst in_ready", 32'(ins_if.in_ready), 32'd1);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst err_sticky", 32'(err_sticky), 32'd0);
    chk("rst alu_a", 32'(alu_a), 32'd0);
    chk("rst alu_b", 32'(alu_b), 32'd0);
    chk("rst alu_sel", 32'(alu_sel), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), v);
      chk($sformatf("rst reg%0d", i), 32'(v), 32'd0);
    end

    // reg1 = 0 + 3
    run("imm_add", OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 2'b11, 2'b00, 2'b11, 2'b11, 4'b0000);
    rd_reg(2'd1, v); chk("imm_add reg1", 32'(v), 32'd3);

    // reg2 = 3 + 1 -> 0 with carry
    run("carry_zero", OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 2'b01, 2'b11, 2'b01, 2'b00, 4'b0011);
    rd_reg(2'd2, v); chk("carry_zero reg2", 32'(v), 32'd0);

    // reg3 = 1, then reg3 = reg3 + reg3 (rs1==rs2==rd, register operand path)
    run("set1", OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 2'b01, 2'b00, 2'b01, 2'b01, 4'b0000);
    run("ovf", OP_ADD, 2'd3, 2'd3, 2'd3, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 4'b0100);
    rd_reg(2'd3, v); chk("ovf reg3", 32'(v), 32'd2);

    run("err", OP_BAD, 2'd1, 2'd1, 2'd0, 1'b1, 2'b01, 2'b11, 2'b01, 2'b00, 4'b1001);
    rd_reg(2'd1, v); chk("err reg1", 32'(v), 32'd3);
    chk("err sticky", 32'(err_sticky), 32'd1);

    // reg0 = reg3 + 1 = 3; sticky stays set
    run("post_err", OP_ADD, 2'd0, 2'd3, 2'd0, 1'b1, 2'b01, 2'b10, 2'b01, 2'b11, 4'b0000);
    chk("post_err sticky", 32'(err_sticky), 32'd1);
    rd_reg(2'd0, v); chk("post_err reg0", 32'(v), 32'd3);

    // reset while the OR is in EXEC
    dc = done_cnt;
    start("rst_mid", OP_OR, 2'd0, 2'd1, 2'd0, 1'b1, 2'b01, 2'b11, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid in_ready", 32'(ins_if.in_ready), 32'd1);
    chk("rst_mid done", 32'(done), 32'd0);
    tick(); tick();
    chk("rst_mid done_cnt", 32'(done_cnt), 32'(dc));
    rd_reg(2'd0, v); chk("rst_mid reg0", 32'(v), 32'd0);
    chk("rst_mid sticky", 32'(err_sticky), 32'd0);
    chk("rst_mid result", 32'(result), 32'd0);
    chk("rst_mid flags", 32'(flags), 32'd0);

    // backpressure: valid held across two instructions
    dc = done_cnt;
    hs_n = 0;
    drive(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 2'b01);
    ins_if.in_valid = 1'b1;
    tick();
    drive(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 2'b10);
    tick();
    chk("bp wb_ready", 32'(ins_if.in_ready), 32'd0);
    tick();
    chk("bp idle_ready", 32'(ins_if.in_ready), 32'd1);
    tick();
    ins_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp hs_n", 32'(hs_n), 32'd2);
    chk("bp spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
    chk("bp done_cnt", 32'(done_cnt - dc), 32'd2);
    rd_reg(2'd1, v); chk("bp reg1", 32'(v), 32'd1);
    rd_reg(2'd2, v); chk("bp reg2", 32'(v), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Sequencing stage directly upstream of the 2-bit combinational ALU.
- Accepts one instruction at a time over a valid/ready handshake and holds a 4-entry register file.
- Drives the ALU operands and opcode, captures the ALU result and flags, and writes the result back to the register file.
- Gives the combinational ALU a registered, multi-instruction context and sticky status flags.

Parameters:
- WIDTH, 2, datapath width; must match the ALU operand width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  instruction present
- in_ready  output  1  stage can accept an instruction
- in_op  input  4  ALU opcode, passed through unmodified
- in_rd  input  2  destination register index
- in_rs1  input  2  source register for operand a
- in_rs2  input  2  source register for operand b
- in_imm_en  input  1  1: operand b = in_imm, rs2 ignored
- in_imm  input  WIDTH  immediate operand
- alu_a  output  WIDTH  to ALU a
- alu_b  output  WIDTH  to ALU b
- alu_sel  output  4  to ALU sel
- alu_out  input  WIDTH  ALU result
- alu_error  input  1  ALU invalid-opcode flag
- alu_zero  input  1  ALU zero flag
- alu_carry  input  1  ALU carry flag
- alu_overflow  input  1  ALU overflow flag
- done  output  1  one-cycle pulse, writeback cycle
- result  output  WIDTH  registered result of last completed op
- flags  output  4  {error, overflow, carry, zero} of last completed op
- err_sticky  output  1  set on any errored op; cleared only by rst
- dbg_addr  input  2  register-file debug read address
- dbg_data  output  WIDTH  combinational read of reg[dbg_addr]

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; all 4 registers=0; result=0; flags=0; err_sticky=0; done=0.
  - Captured instruction fields=0, so alu_a=alu_b=0 and alu_sel=0.
  - Takes priority over everything, including mid-operation: the in-flight instruction is dropped and no writeback occurs.
- FSM states: IDLE, EXEC, WB. in_ready=1 only in IDLE, derived combinationally from state.
- IDLE:
  - If in_valid&&in_ready at an edge: latch op, rd, rs1, rs2, imm_en, imm; go to EXEC.
  - Otherwise stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_a=reg[rs1_q]; alu_b = imm_en_q ? imm_q : reg[rs2_q]; alu_sel=op_q.
  - At the end of the cycle, latch alu_out into result and {alu_error, alu_overflow, alu_carry, alu_zero} into flags; go to WB.
- WB (exactly 1 cycle):
  - done=1.
  - If flags[3]==0: reg[rd_q] <= result at the end of the cycle.
  - If flags[3]==1: no register write; err_sticky <= 1.
  - Go to IDLE.
- ALU outputs are held (alu_a, alu_b, alu_sel keep the last captured instruction) in IDLE and WB, so the ALU inputs never toggle spuriously.
- Latency and throughput:
  - Handshake edge T: EXEC in cycle T+1, done high in T+2.
  - Register update visible on dbg_data from T+3.
  - Throughput 1 instruction per 3 cycles.
- Operand read: in EXEC, rs1==rs2==rd is legal; reads return the pre-write value.
- Data hazards: none, because the stage is strictly sequential. The next instruction's EXEC is at least T+4, after the writeback.
- Width rules:
  - All operand values are WIDTH bits; no sign extension.
  - result is truncated to WIDTH; carry comes only from the ALU flag.
- Flag persistence: result and flags hold their last-completed values until the next WB or rst.
- in_valid while not ready: ignored; no queuing. The upstream master must hold the instruction until it sees in_ready.
- dbg_data reflects register contents at all times, including during reset.

Test Plan:
- Reset: assert rst for 2 cycles, then release -> in_ready=1, done=0, result=0, flags=4'b0000, dbg_data=0 for all 4 addresses.
- Immediate ADD: OP_ADD, rs1=0, imm_en=1, imm=2'b11, rd=1 -> done pulses 2 cycles after the handshake, result=2'b11, flags=4'b0000, reg1=3.
- Carry plus zero: with reg1=3, OP_ADD, rs1=1, imm=2'b01, rd=2 -> result=2'b00, flags=4'b0011 (carry=1, zero=1), reg2=0.
- Signed overflow: OP_ADD 2'b01+2'b01 into rd=3 -> result=2'b10, flags=4'b0100, reg3=2'b10.
- Error path: an undefined opcode with rd=1 -> flags=4'b1001 (error=1, zero=1 because the ALU outputs 0), reg1 unchanged at 3, err_sticky=1; a following valid ADD leaves err_sticky=1.
- Reset mid-op: handshake an OP_OR into rd=0, assert rst during EXEC -> no done pulse, reg0=0, state=IDLE and in_ready=1 on the cycle after rst deasserts.
- Backpressure: hold in_valid=1 continuously with two different instructions -> each is accepted only when in_ready=1 (accepts 3 cycles apart), with exactly one done pulse per instruction.
